// File: rtl/maxpool_window.sv
// maxpool_window: streaming max-pool over WIN beats of LANES elements with argmax index
module maxpool_window #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int WIN    = 4,
    parameter bit SIGNED = 1'b1,
    parameter int IDX_W  = (LANES * WIN > 1) ? $clog2(LANES * WIN) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int S  = $clog2(LANES);
    localparam int LW = (S > 0) ? S : 1;
    localparam int SQ = (S > 0) ? S : 1;
    localparam int NQ = (LANES > 1) ? LANES - 1 : 1;
    localparam int NT = 2 * LANES - 1;
    localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

    logic              adv;
    logic [DATA_W-1:0] val_d [NQ];
    logic [DATA_W-1:0] val_q [NQ];
    logic [LW-1:0]     lane_d [NQ];
    logic [LW-1:0]     lane_q [NQ];
    logic [SQ-1:0]     vld_d, vld_q, lst_d, lst_q;
    logic [DATA_W-1:0] t_val [NT];
    logic [LW-1:0]     t_lane [NT];
    logic              t_vld, t_lst, close, take;
    logic [IDX_W-1:0]  new_idx;
    logic [DATA_W-1:0] acc_val_d, acc_val_q;
    logic [IDX_W-1:0]  acc_idx_d, acc_idx_q;
    logic              acc_done_d, acc_done_q;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    logic [IDX_W-1:0]  out_idx_d, out_idx_q;
    logic              out_valid_d, out_valid_q;

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return SIGNED ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;

    // Heap-ordered view of the tree: input lanes first, then each registered level; node LANES+p has children 2p, 2p+1
    always_comb begin
        for (int e = 0; e < LANES; e++) begin
            t_val[e]  = in_data[e*DATA_W +: DATA_W];
            t_lane[e] = LW'(e);
        end
        for (int e = 0; e < LANES - 1; e++) begin
            t_val[LANES+e]  = val_q[e];
            t_lane[LANES+e] = lane_q[e];
        end
    end

    // Pairwise compare for every tree node; right child wins only when strictly greater so ties keep the lower lane
    always_comb begin
        for (int p = 0; p < NQ; p++) begin
            val_d[p]  = val_q[p];
            lane_d[p] = lane_q[p];
        end
        for (int p = 0; p < LANES - 1; p++) begin
            val_d[p]  = gt(t_val[2*p+1], t_val[2*p]) ? t_val[2*p+1]  : t_val[2*p];
            lane_d[p] = gt(t_val[2*p+1], t_val[2*p]) ? t_lane[2*p+1] : t_lane[2*p];
        end
        vld_d = SQ'({vld_q, in_valid});
        lst_d = SQ'({lst_q, in_last});
    end

    // Accumulate across beats, close the window on the last beat or the counter limit, then publish
    always_comb begin
        t_vld       = (S > 0) ? vld_q[SQ-1] : in_valid;
        t_lst       = (S > 0) ? lst_q[SQ-1] : in_last;
        close       = t_lst || (cnt_q == CW'(WIN - 1));
        take        = (cnt_q == '0) || gt(t_val[NT-1], acc_val_q);
        new_idx     = IDX_W'(cnt_q) * IDX_W'(LANES) + IDX_W'(t_lane[NT-1]);
        acc_val_d   = (t_vld && take) ? t_val[NT-1] : acc_val_q;
        acc_idx_d   = (t_vld && take) ? new_idx : acc_idx_q;
        acc_done_d  = t_vld && close;
        cnt_d       = !t_vld ? cnt_q : (close ? '0 : cnt_q + 1'b1);
        out_valid_d = acc_done_q;
        out_data_d  = acc_done_q ? acc_val_q : out_data_q;
        out_idx_d   = acc_done_q ? acc_idx_q : out_idx_q;
    end

    // Every stage advances together and freezes while a result waits downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q       <= '{default: '0};
            lane_q      <= '{default: '0};
            vld_q       <= '0;
            lst_q       <= '0;
            acc_val_q   <= '0;
            acc_idx_q   <= '0;
            acc_done_q  <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            val_q       <= val_d;
            lane_q      <= lane_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_val_q   <= acc_val_d;
            acc_idx_q   <= acc_idx_d;
            acc_done_q  <= acc_done_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_maxpool_window.sv
// tb_maxpool_window: directed checks of max/argmax, latency, stall, reset and streaming
module tb_maxpool_window;
    typedef struct packed {
        logic [15:0] sd;
        logic [3:0]  si;
        logic [15:0] ud;
        logic [3:0]  ui;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, u_in_ready;
    logic [15:0] out_data, u_out_data;
    logic [3:0]  out_idx, u_out_idx;
    logic        out_valid, u_out_valid;
    int          total = 0;
    int          bad = 0;
    int          waited = 0;
    int          n_push = 0;
    int          n_seen = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic [3:0]  hold_i = '0;

    always #5 clk = ~clk;

    maxpool_window dut_s (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    maxpool_window #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(u_in_ready), .out_data(u_out_data), .out_idx(u_out_idx), .out_valid(u_out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_res(input int sd, input int si, input int ud, input int ui);
        exp_t e;
        e.sd = sd[15:0];
        e.si = si[3:0];
        e.ud = ud[15:0];
        e.ui = ui[3:0];
        q.push_back(e);
        n_push++;
    endtask

    task automatic send(input logic [63:0] d, input logic last);
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 100) begin
                chk("send_timeout", waited, 0);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            chk("u_ready", u_in_ready, in_ready);
            chk("u_valid", u_out_valid, out_valid);
            if (hold_v) begin
                chk("hold_data", out_data, hold_d);
                chk("hold_idx", out_idx, hold_i);
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    n_seen++;
                    chk("s_data", out_data, mon_e.sd);
                    chk("s_idx", out_idx, mon_e.si);
                    chk("u_data", u_out_data, mon_e.ud);
                    chk("u_idx", u_out_idx, mon_e.ui);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_i = out_idx;
        end
    end

    initial begin
        tick(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", in_ready, 1);
        tick(1);

        expect_res(9, 6, 'hFFF9, 8);
        send(pk(1, 5, 3, 2), 1'b0);
        send(pk(4, 4, 9, 0), 1'b0);
        send(pk(-7, 8, 9, 1), 1'b0);
        send(pk(0, 0, 0, 0), 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("latency", out_valid, k == 3);
        end
        tick(4);

        expect_res(3, 3, 'hFFFF, 0);
        send(pk('hFFFF, 1, 2, 3), 1'b1);
        tick(6);

        expect_res(5, 0, 5, 0);
        for (int b = 0; b < 4; b++) send(pk(5, 5, 5, 5), 1'b0);
        expect_res(9, 4, 9, 4);
        send(pk(1, 2, 3, 4), 1'b0);
        send(pk(9, 0, 0, 0), 1'b1);
        expect_res(7, 1, 7, 1);
        send(pk(0, 7, 0, 0), 1'b0);
        send(pk(1, 1, 1, 1), 1'b0);
        send(pk(2, 2, 2, 2), 1'b0);
        send(pk(3, 3, 3, 3), 1'b0);
        expect_res(6, 12, 6, 12);
        for (int b = 0; b < 3; b++) send(pk(1, 1, 1, 1), 1'b0);
        send(pk(6, 1, 1, 1), 1'b1);
        expect_res(2, 0, 2, 0);
        send(pk(2, 0, 0, 0), 1'b1);
        tick(6);

        expect_res(25, 15, 25, 15);
        expect_res(50, 0, 50, 0);
        out_ready = 1'b0;
        fork
            begin
                for (int b = 0; b < 4; b++) send(pk(b*4+10, b*4+11, b*4+12, b*4+13), 1'b0);
                send(pk(50, 1, 1, 1), 1'b0);
                for (int b = 0; b < 3; b++) send(pk(1, 1, 1, 1), 1'b0);
            end
            begin
                tick(10);
                out_ready = 1'b1;
            end
        join
        tick(8);

        send(pk(90, 90, 90, 90), 1'b0);
        send(pk(91, 91, 91, 91), 1'b0);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_idx", out_idx, 0);
        rst = 1'b0;
        chk("mid_rst_rdy", in_ready, 1);
        expect_res(8, 7, 8, 7);
        send(pk(1, 2, 3, 4), 1'b0);
        send(pk(5, 6, 7, 8), 1'b0);
        send(pk(0, 0, 0, 0), 1'b0);
        send(pk(0, 0, 0, 0), 1'b0);
        tick(8);

        for (int w = 0; w < 8; w++) begin
            int tb_b;
            int tb_l;
            tb_b = w % 4;
            tb_l = (w * 3) % 4;
            expect_res(100 + w, tb_b * 4 + tb_l, 100 + w, tb_b * 4 + tb_l);
            for (int b = 0; b < 4; b++) begin
                int v[4];
                for (int l = 0; l < 4; l++) begin
                    v[l] = b * 4 + l;
                    if ((b == tb_b && l == tb_l) || (b == 3 && l == 3)) v[l] = 100 + w;
                end
                send(pk(v[0], v[1], v[2], v[3]), 1'b0);
                chk("stream_rdy", waited, 0);
            end
        end
        tick(10);

        chk("sb_drain", q.size(), 0);
        chk("result_count", n_seen, n_push);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/maxpool_window.md
MAXPOOL_WINDOW -- requirements
Module: maxpool_window

Interface
REQ-001 Parameter DATA_W, default 16, bit width of each element.
REQ-002 Parameter LANES, default 4, elements per input beat; SHALL be a power of two, 1..32.
REQ-003 Parameter WIN, default 4, beats per pooling window, 1..256.
REQ-004 Parameter SIGNED, default 1; 1 = two's-complement compare, 0 = unsigned compare.
REQ-005 Parameter IDX_W, default clog2(LANES*WIN) (minimum 1), width of the argmax index.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 in_data  input  LANES*DATA_W  packed elements; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-009 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-010 in_last  input  1  this beat closes the current window early.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 out_data  output  DATA_W  window maximum.
REQ-013 out_idx  output  IDX_W  argmax index, equal to beat_no*LANES + lane within the window.
REQ-014 out_valid  output  1  out_data/out_idx hold a result.
REQ-015 out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both high; a result is consumed when out_valid and out_ready are both high.
REQ-017 Global advance = !out_valid | out_ready; in_ready SHALL equal advance, combinationally, with no dependence on in_valid.
REQ-018 When advance is low, every pipeline register, the beat counter and the accumulator SHALL hold their values.
REQ-019 Lane reduction SHALL be a comparator tree of S = log2(LANES) registered stages, each stage carrying its own valid bit, the value, the lane index and last-beat status; when LANES = 1, S = 0.
REQ-020 Comparisons SHALL follow SIGNED; ties SHALL resolve to the lower index, both within the tree and across beats.
REQ-021 The accumulator stage SHALL load the tree output on the first beat of a window and thereafter replace it only when the new value is strictly greater.
REQ-022 Beat counter: 0..WIN-1; it increments per beat reaching the accumulator and returns to 0 when a window closes.
REQ-023 A window SHALL close on the beat where the counter equals WIN-1, or on a beat flagged in_last, whichever comes first; in_last on beat WIN-1 SHALL close exactly one window.
REQ-024 On close, out_data/out_idx SHALL be loaded with the final max and index and out_valid SHALL be set on the next edge.
REQ-025 Latency: with no stall, out_valid SHALL rise S+1 cycles after the edge that accepts the closing beat.
REQ-026 Consume and close in the same cycle SHALL load the new result, leaving out_valid high; consume without close SHALL clear out_valid.
REQ-027 Throughput: with out_ready held high, one beat SHALL be accepted every cycle, including back-to-back windows, with no bubble.
REQ-028 out_data/out_idx SHALL stay stable while out_valid is high and out_ready is low.

Reset
REQ-029 While rst is high, out_valid, all stage valids, the beat counter, out_data and out_idx SHALL be 0 at the next edge, with the accumulator cleared.
REQ-030 A partial window in flight when rst asserts SHALL be discarded, and no result for it SHALL ever appear.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 Defaults; beats {1,5,3,2},{4,4,9,0},{-7,8,9,1},{0,0,0,0}, out_ready=1 -> one result, out_data=9, out_idx=6, out_valid rising 3 cycles after the 4th beat is accepted.
REQ-033 SIGNED=0; beat {0xFFFF,1,2,3} with in_last=1 -> out_data=0xFFFF, out_idx=0; the same beat with SIGNED=1 gives out_data=3, out_idx=3.
REQ-034 All-equal window of 5s -> out_data=5, out_idx=0; in_last on the 2nd beat -> a result after 2 beats, and the counter restarts at 0.
REQ-035 Hold out_ready=0 for 10 cycles while streaming -> out_data stable, in_ready=0 while out_valid is high, no beat lost or duplicated after release.
REQ-036 Assert rst after 2 beats of a window -> out_valid stays 0; the next full window yields only its own max and index.
REQ-037 Streaming 8 windows with out_ready=1 -> in_ready constantly 1, 8 results each matching the reference max and argmax.
